// File: rtl/leaf_pkg.sv
// Shared types and helpers for the page-leaf output arbiter.
package leaf_pkg;

    // Default beat width of a leaf output stream.
    localparam int PAYLOAD_BITS_DEF = 32;

    // Arbiter states: no owner, or one requester owns the output port.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a requester index; at least one bit so a single-entry range stays legal.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Round-robin first-one finder: the first set bit of elig at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import leaf_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDX_BITS = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  elig,
    input  logic [IDX_BITS-1:0] ptr,
    output logic                found,
    output logic [IDX_BITS-1:0] idx
);

    // Walk NUM_REQ positions starting at ptr and keep the first eligible one.
    always_comb begin
        int pos;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = int'(ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && elig[pos]) begin
                found = 1'b1;
                idx   = IDX_BITS'(pos);
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Shares one leaf output port among NUM_REQ operator streams: round-robin
// grants of at most BURST_LEN beats, one IDLE bubble after every release.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
    parameter int BURST_LEN    = 16,
    parameter int IDX_BITS     = idx_bits(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            ap_rst_n,
    input  logic [NUM_REQ-1:0]              req_en,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]              req_tvalid,
    output logic [NUM_REQ-1:0]              req_tready,
    output logic [PAYLOAD_BITS-1:0]         out_data,
    output logic                            out_vld,
    input  logic                            out_ack,
    output logic [IDX_BITS-1:0]             out_idx,
    output logic                            busy
);

    localparam int                  CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NUM_REQ - 1);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [IDX_BITS-1:0]   grant_q;
    logic [IDX_BITS-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  pick_found;
    logic [IDX_BITS-1:0]   pick_idx;
    logic                  sel_vld;
    logic [PAYLOAD_BITS-1:0] sel_data;
    logic                  in_grant;
    logic                  xfer;
    logic                  rel_grant;
    logic [IDX_BITS-1:0]   next_ptr;

    // Enable mask only matters while scanning in IDLE.
    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .IDX_BITS (IDX_BITS)
    ) u_pick (
        .elig  (req_tvalid & req_en),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the granted requester's valid and data from the registered grant.
    always_comb begin
        sel_vld  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_BITS'(i)) begin
                sel_vld  = req_tvalid[i];
                sel_data = req_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // Forward the granted stream; ready goes back only to the owner.
    always_comb begin
        in_grant = (state_q == GRANT);
        busy     = in_grant;
        out_vld  = in_grant & sel_vld;
        out_data = in_grant ? sel_data : '0;
        out_idx  = grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tready[i] = in_grant && (grant_q == IDX_BITS'(i)) && out_ack;
        end
        xfer      = out_vld & out_ack;
        rel_grant = in_grant && (!sel_vld || (xfer && (cnt_q == CNT_LAST)));
        next_ptr  = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
    end

    // Next-state: take a grant when the scan finds someone, drop it on release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = GRANT;
            GRANT:   if (rel_grant)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant owner, beat counter within the burst, and round-robin pointer.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (state_q == IDLE) begin
            if (pick_found) begin
                grant_q <= pick_idx;
                cnt_q   <= '0;
            end
        end else if (rel_grant) begin
            rr_ptr_q <= next_ptr;
        end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
